count_tick_gen: RTL and testbench
=================================

# count_tick_gen

Programmable enable-pulse generator that sits directly upstream of the 4-bit `counter` and drives its `en` input. It divides `clk` by a run-time divisor and issues single-cycle `en` pulses, free-running or as a finite burst, under a start/stop handshake. This replaces hand-driven `en` levels with a deterministic tick source, so downstream count values are predictable cycle-for-cycle.

## Interface
- DIV_W, 8, width of divisor input and prescaler
- BURST_W, 4, width of burst length and tick counter; matches the downstream counter width
- clk  in  1  rising-edge clock, shared with downstream counter
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  level, sampled each edge; launches a run from IDLE
- stop  in  1  level, sampled each edge; aborts a run
- div  in  DIV_W  pulse period minus one, latched at start
- burst_len  in  BURST_W  ticks per burst, latched at start; 0 = free-running
- en  out  1  registered single-cycle tick, connects to counter `en`
- busy  out  1  high while in RUN
- done  out  1  single-cycle, coincident with final tick of a burst
- tick_cnt  out  BURST_W  ticks issued since last start

## Operation
- FSM states: IDLE, RUN.
- IDLE: en=0, busy=0. start=1 and stop=0 at an edge → latch div into div_q, burst_len into len_q, load prescaler with div, clear tick_cnt, go RUN.
- RUN, each edge with stop=0: prescaler==0 → en<=1, prescaler<=div_q, tick_cnt<=tick_cnt+1; else en<=0, prescaler<=prescaler-1.
- Burst end: tick issued with len_q!=0 and tick_cnt+1==len_q → done<=1 with that en, state<=IDLE at the same edge.
- stop=1 in RUN → IDLE at that edge; en and done forced 0 (stop beats a due tick). tick_cnt holds its value.
- start while RUN: ignored. start and stop together in IDLE: stay IDLE.
- div and burst_len changes during RUN have no effect; only latched copies are used.
- tick_cnt wraps modulo 2^BURST_W in free-running mode.
- All outputs registered; no combinational input-to-output path.

## Timing
- Reset (rst=0): state=IDLE, en=0, busy=0, done=0, tick_cnt=0, prescaler=0, div_q=0, len_q=0; takes effect immediately, independent of clk.
- Reset mid-run: run abandoned, no pulse completes; after rst deasserts, a new start is required.
- start sampled at edge E0 → busy high after E0; first en high after edge E(div+1); later pulses every div+1 cycles.
- div=0 → en high every cycle after E1 (continuous enable).
- en is one cycle wide unless div=0.
- Burst of N ticks: busy falls at the edge that raises the N-th en and done; both drop one edge later.

## Configuration
- TICK_GEN_BURST_EN defined: burst termination and done are active as above.
- Not defined: burst_len ignored, len_q absent, every run free-runs until stop or reset, done tied 0; tick_cnt still counts and wraps.

## Structure
- Package count_tick_pkg: state enum (IDLE, RUN), default DIV_W/BURST_W localparams, reset-value constants.
- One sub-module, tick_prescaler: loadable down-counter with reload-on-zero and a `hit` output; the FSM, latches and tick counter stay in count_tick_gen.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 → en=0, busy=0, done=0, tick_cnt=0; release → IDLE until a start edge after release.
- Free-run: div=3, burst_len=0, start pulse → first en 4 cycles after the start edge, then every 4 cycles; downstream counter reads 5 after 20 further cycles.
- Burst (macro on): div=1, burst_len=5 → exactly 5 en pulses 2 cycles apart, done with 5th, busy low next cycle, tick_cnt=5, counter=5.
- Stop collision: div=2, stop asserted on the cycle a tick is due → no en, IDLE, tick_cnt unchanged.
- div=0, burst_len=15 → en high for 15 consecutive cycles, done on the last; counter reaches 15 without wrap.
- Macro off: div=0, burst_len=3 → en continuous past 3 ticks, done never asserts, tick_cnt wraps 15→0 after 16 ticks.

Source files
------------

// File: rtl/count_tick_pkg.sv
// count_tick_gen shared types: FSM state encoding, default widths
// and reset values for the tick generator registers.
package count_tick_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DIV_W_DEF   = 8;
  localparam int BURST_W_DEF = 4;

  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_EN    = 1'b0;
  localparam logic   RST_DONE  = 1'b0;

endpackage

// File: rtl/count_tick_gen_if.sv
// Control/status bundle between a run controller (master)
// and the tick generator (slave).
interface count_tick_gen_if #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
);

  logic               start;
  logic               stop;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst_len;
  logic               en;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] tick_cnt;

  modport master (
    output start, stop, div, burst_len,
    input  en, busy, done, tick_cnt
  );

  modport slave (
    input  start, stop, div, burst_len,
    output en, busy, done, tick_cnt
  );

endinterface

// File: rtl/tick_prescaler.sv
// Loadable down-counter; reloads on zero while running and
// flags the zero count on o_hit.
module tick_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_run,
  input  logic [W-1:0] i_val,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;

  assign o_hit = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_run) begin
      r_cnt <= o_hit ? i_val : r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/count_tick_gen.sv
// Programmable enable-pulse generator for the downstream counter.
// Define TICK_GEN_BURST_EN for finite bursts with done.
module count_tick_gen
  import count_tick_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  count_tick_gen_if.slave  bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_en;
  logic               w_en_nxt;
  logic [BURST_W-1:0] r_tick_cnt;
  logic [BURST_W-1:0] w_tick_nxt;
  logic [BURST_W-1:0] w_tick_inc;
  logic [DIV_W-1:0]   r_div_q;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [DIV_W-1:0]   w_psc_val;
  logic               w_load;
  logic               w_run;
  logic               w_hit;

`ifdef TICK_GEN_BURST_EN
  logic [BURST_W-1:0] r_len_q;
  logic [BURST_W-1:0] w_len_nxt;
  logic               r_done;
  logic               w_done_nxt;
`endif

  assign w_tick_inc = r_tick_cnt + BURST_W'(1);
  // start loads the live divisor; reloads use the latched copy
  assign w_psc_val  = w_load ? bus.div : r_div_q;

  tick_prescaler #(
    .W (DIV_W)
  ) u_psc (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_run  (w_run),
    .i_val  (w_psc_val),
    .o_hit  (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_tick_nxt  = r_tick_cnt;
    w_div_nxt   = r_div_q;
    w_load      = 1'b0;
    w_run       = 1'b0;
`ifdef TICK_GEN_BURST_EN
    w_len_nxt   = r_len_q;
    w_done_nxt  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = RUN;
          w_div_nxt   = bus.div;
          w_tick_nxt  = '0;
          w_load      = 1'b1;
`ifdef TICK_GEN_BURST_EN
          w_len_nxt   = bus.burst_len;
`endif
        end
      end
      RUN: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_run = 1'b1;
          if (w_hit) begin
            w_en_nxt   = 1'b1;
            w_tick_nxt = w_tick_inc;
`ifdef TICK_GEN_BURST_EN
            if (r_len_q != '0 && w_tick_inc == r_len_q) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RST_STATE;
      r_en       <= RST_EN;
      r_tick_cnt <= '0;
      r_div_q    <= '0;
`ifdef TICK_GEN_BURST_EN
      r_len_q    <= '0;
      r_done     <= RST_DONE;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_en       <= w_en_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_div_q    <= w_div_nxt;
`ifdef TICK_GEN_BURST_EN
      r_len_q    <= w_len_nxt;
      r_done     <= w_done_nxt;
`endif
    end
  end

  assign bus.en       = r_en;
  assign bus.busy     = (r_state == RUN);
  assign bus.tick_cnt = r_tick_cnt;
`ifdef TICK_GEN_BURST_EN
  assign bus.done     = r_done;
`else
  assign bus.done     = 1'b0;
`endif

endmodule

// File: tb/tb_count_tick_gen.sv
// Bench for count_tick_gen: run table plus reset/idle sequences.
// Expected en cycles are queued at start and popped as en arrives.
module tb_count_tick_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  count_tick_gen_if #(.DIV_W(8), .BURST_W(4)) bus ();

  count_tick_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int div;
    int blen;
    int stop_at;
    int poke_at;
    int cycles;
    int exp_ticks;
    int exp_tcnt;
    int exp_done;
    bit exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ndone;
    int cnt_model;
    int exp_c;
    ndone     = 0;
    cnt_model = 0;
    sb.delete();
    for (int k = 1; k <= v.exp_ticks; k++)
      sb.push_back(k * (v.div + 1));
    bus.div       = 8'(v.div);
    bus.burst_len = 4'(v.blen);
    bus.start     = 1'b1;
    bus.stop      = 1'b0;
    tick();
    bus.start = 1'b0;
    check($sformatf("v%0d_busy_after_start", idx), int'(bus.busy), 1);
    check($sformatf("v%0d_tcnt_cleared", idx), int'(bus.tick_cnt), 0);
    for (int c = 1; c <= v.cycles; c++) begin
      bus.stop  = (c == v.stop_at);
      bus.start = (c == v.poke_at);
      if (c == v.poke_at) begin
        bus.div       = 8'd0;
        bus.burst_len = 4'd1;
      end
      tick();
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      if (bus.en) begin
        cnt_model = (cnt_model + 1) % 16;
        exp_c = (sb.size() > 0) ? sb.pop_front() : -1;
        check($sformatf("v%0d_en_cycle", idx), c, exp_c);
      end
      if (bus.done) begin
        ndone++;
        check($sformatf("v%0d_done_with_en", idx), int'(bus.en), 1);
        check($sformatf("v%0d_busy_low_at_done", idx), int'(bus.busy), 0);
      end
    end
    check($sformatf("v%0d_missing_en", idx), sb.size(), 0);
    check($sformatf("v%0d_tick_cnt", idx), int'(bus.tick_cnt), v.exp_tcnt);
    check($sformatf("v%0d_counter", idx), cnt_model, v.exp_ticks % 16);
    check($sformatf("v%0d_done_count", idx), ndone, v.exp_done);
    check($sformatf("v%0d_busy_end", idx), int'(bus.busy), int'(v.exp_busy));
    if (bus.busy) begin
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check($sformatf("v%0d_stop_idle", idx), int'(bus.busy), 0);
      check($sformatf("v%0d_stop_no_en", idx), int'(bus.en), 0);
    end
    tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.div       = 8'd0;
    bus.burst_len = 4'd0;

`ifdef TICK_GEN_BURST_EN
    vecs.push_back(vec_t'{3, 0, 0, 0, 20, 5, 5, 0, 1});
    vecs.push_back(vec_t'{1, 5, 0, 0, 14, 5, 5, 1, 0});
    vecs.push_back(vec_t'{2, 0, 6, 0, 8, 1, 1, 0, 0});
    vecs.push_back(vec_t'{0, 15, 0, 0, 18, 15, 15, 1, 0});
    vecs.push_back(vec_t'{5, 0, 4, 0, 6, 0, 0, 0, 0});
    vecs.push_back(vec_t'{3, 0, 0, 2, 9, 2, 2, 0, 1});
    vecs.push_back(vec_t'{2, 3, 5, 0, 8, 1, 1, 0, 0});
`else
    vecs.push_back(vec_t'{3, 0, 0, 0, 20, 5, 5, 0, 1});
    vecs.push_back(vec_t'{1, 5, 0, 0, 14, 7, 7, 0, 1});
    vecs.push_back(vec_t'{2, 0, 6, 0, 8, 1, 1, 0, 0});
    vecs.push_back(vec_t'{0, 3, 0, 0, 18, 18, 2, 0, 1});
    vecs.push_back(vec_t'{5, 0, 4, 0, 6, 0, 0, 0, 0});
    vecs.push_back(vec_t'{3, 0, 0, 2, 9, 2, 2, 0, 1});
`endif

    // reset held with start asserted
    #2 rst = 1'b0;
    bus.start = 1'b1;
    bus.div   = 8'd3;
    repeat (3) tick();
    check("rst_en", int'(bus.en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_tick_cnt", int'(bus.tick_cnt), 0);
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", int'(bus.busy), 0);
    check("post_rst_no_en", int'(bus.en), 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.div   = 8'd0;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_idle", int'(bus.busy), 0);
    tick();
    check("start_stop_no_en", int'(bus.en), 0);

    // asynchronous reset in the middle of a run
    bus.div       = 8'd1;
    bus.burst_len = 4'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    check("mid_en_before_rst", int'(bus.en), 1);
    check("mid_tcnt_before_rst", int'(bus.tick_cnt), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_en", int'(bus.en), 0);
    check("mid_rst_tcnt", int'(bus.tick_cnt), 0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("after_rst_no_en", int'(bus.en), 0);
    end
    check("after_rst_idle", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
